// File: rtl/pipe_stage_reg_pkg.sv
//------------------------------------------------------------------------------
// Module : pipe_pkg
// Brief  : Shared state encoding and widths for the pipeline stage register.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
//------------------------------------------------------------------------------
// Module : pipe_stage_reg_if
// Brief  : Upstream/downstream handshake bundle of a pipeline stage register.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = 48,
  parameter int CTRL_W = 24
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic [CTRL_W-1:0]      in_ctrl;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [CTRL_W-1:0]      out_ctrl;
  logic [STALL_CNT_W-1:0] stall_cnt;

  // Environment side: drives the upstream stage and the downstream consumer.
  modport master (
    output in_valid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

  // Stage register side.
  modport slave (
    input  in_valid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, stall_cnt
  );

endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
//------------------------------------------------------------------------------
// Module : pipe_sat_counter
// Brief  : Up-counter that sticks at all-ones; synchronous clear.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             Clk,
  input  wire logic             Rst,
  input  wire logic             inc,
  input  wire logic             clr,
  output logic      [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module : pipe_stage_reg
// Brief  : Inter-stage pipeline register with 2-entry skid buffer, flush and
//          bubble insertion. Optional stall counter under PIPE_STALL_CNT_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W = 48,
  parameter int                CTRL_W = 24,
  parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
  input wire logic        Clk,
  input wire logic        Rst,
  pipe_stage_reg_if.slave bus
);

  state_t            r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // The main entry is the output register; its control field is forced to
  // BUBBLE whenever it holds no valid instruction.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_ctrl <= BUBBLE;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (bus.flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_ctrl <= BUBBLE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_main_data <= bus.in_data;
            r_main_ctrl <= bus.in_ctrl;
          end else if (w_in_fire) begin
            r_skid_data <= bus.in_data;
            r_skid_ctrl <= bus.in_ctrl;
            r_in_ready  <= 1'b0;
            r_state     <= TWO;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_main_ctrl <= BUBBLE;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_main_data <= r_skid_data;
            r_main_ctrl <= r_skid_ctrl;
            r_in_ready  <= 1'b1;
            r_state     <= ONE;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_main_ctrl <= BUBBLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main_data;
  assign bus.out_ctrl  = r_main_ctrl;

`ifdef PIPE_STALL_CNT_EN
  logic w_stall;

  assign w_stall = r_out_valid & ~bus.out_ready;

  pipe_sat_counter #(
    .WIDTH (STALL_CNT_W)
  ) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (w_stall),
    .clr   (1'b0),
    .count (bus.stall_cnt)
  );
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//------------------------------------------------------------------------------
// Module : tb_pipe_stage_reg
// Brief  : Directed + randomized bench for pipe_stage_reg against a queue model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int          DW        = 48;
  localparam int          CW        = 24;
  localparam logic [23:0] C_BUBBLE  = 24'hA5_0F3C;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W (DW),
    .CTRL_W (CW),
    .BUBBLE (C_BUBBLE)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t q[$];
  int   exp_stall = 0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t rnd_ent();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[71:0];
  endfunction

  task automatic drive(input bit v, input ent_t e, input bit ordy, input bit fl);
    bus.in_valid  = v;
    bus.in_data   = e.d;
    bus.in_ctrl   = e.c;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  // One clock: advance the queue model with the inputs seen at the edge,
  // then optionally compare every observable output.
  task automatic step(input bit do_chk);
    bit ofire, ifire;
    @(posedge Clk);
    if (Rst) begin
      q.delete();
      exp_stall = 0;
    end else begin
`ifdef PIPE_STALL_CNT_EN
      if (q.size() > 0 && !bus.out_ready && exp_stall < 65535) exp_stall++;
`endif
      if (bus.flush) begin
        q.delete();
      end else begin
        ofire = (q.size() > 0) && bus.out_ready;
        ifire = bus.in_valid && (q.size() < 2);
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back({bus.in_data, bus.in_ctrl});
      end
    end
    #1;
    if (do_chk) begin
      chk("m_valid", 72'(bus.out_valid), 72'(q.size() > 0));
      chk("m_ready", 72'(bus.in_ready),  72'(q.size() < 2));
      chk("m_ctrl",  72'(bus.out_ctrl),  72'((q.size() > 0) ? q[0].c : C_BUBBLE));
      if (q.size() > 0) chk("m_data", 72'(bus.out_data), 72'(q[0].d));
      chk("m_stall", 72'(bus.stall_cnt), 72'(exp_stall));
    end
  endtask

  initial begin
    ent_t a, b, e;
    drive(1'b0, '0, 1'b0, 1'b0);

    // Reset state
    Rst = 1'b1;
    step(1); step(1);
    chk("rst_valid", 72'(bus.out_valid), 72'(0));
    chk("rst_ready", 72'(bus.in_ready),  72'(1));
    chk("rst_data",  72'(bus.out_data),  72'(0));
    chk("rst_ctrl",  72'(bus.out_ctrl),  72'(C_BUBBLE));
    chk("rst_stall", 72'(bus.stall_cnt), 72'(0));
    Rst = 1'b0;

    // Streaming 1..8 with one-cycle latency
    for (int k = 1; k <= 8; k++) begin
      e.d = 48'(k); e.c = 24'(k + 16);
      drive(1'b1, e, 1'b1, 1'b0);
      step(1);
      chk("stream_data",  72'(bus.out_data), 72'(k));
      chk("stream_ready", 72'(bus.in_ready), 72'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    step(1);

    // Backpressure: fill both entries, then drain in order
    a = rnd_ent(); b = rnd_ent();
    drive(1'b1, a, 1'b0, 1'b0); step(1);
    drive(1'b1, b, 1'b0, 1'b0); step(1);
    chk("bp_ready", 72'(bus.in_ready), 72'(0));
    drive(1'b1, rnd_ent(), 1'b0, 1'b0); step(1);
    chk("bp_head",  72'(bus.out_data), 72'(a.d));
    drive(1'b0, '0, 1'b1, 1'b0); step(1);
    chk("bp_second", 72'(bus.out_data), 72'(b.d));
    chk("bp_second_ctrl", 72'(bus.out_ctrl), 72'(b.c));
    step(1);
    chk("bp_empty", 72'(bus.out_valid), 72'(0));

    // Flush while full with a concurrent input
    drive(1'b1, rnd_ent(), 1'b0, 1'b0); step(1);
    drive(1'b1, rnd_ent(), 1'b0, 1'b0); step(1);
    drive(1'b1, rnd_ent(), 1'b0, 1'b1); step(1);
    chk("fl_valid", 72'(bus.out_valid), 72'(0));
    chk("fl_ctrl",  72'(bus.out_ctrl),  72'(C_BUBBLE));
    chk("fl_ready", 72'(bus.in_ready),  72'(1));
    drive(1'b0, '0, 1'b1, 1'b0); step(1);
    chk("fl_dropped", 72'(bus.out_valid), 72'(0));

    // Reset with one entry held
    drive(1'b1, rnd_ent(), 1'b0, 1'b0); step(1);
    drive(1'b0, '0, 1'b0, 1'b0);
    Rst = 1'b1; step(1); Rst = 1'b0;
    chk("rmid_valid", 72'(bus.out_valid), 72'(0));
    chk("rmid_data",  72'(bus.out_data),  72'(0));
    chk("rmid_stall", 72'(bus.stall_cnt), 72'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd_ent(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      Rst = ($urandom_range(0, 400) == 0);
      step(1);
    end
    Rst = 1'b0;

    // Long stall: counter saturation (or stays zero when disabled)
    drive(1'b0, '0, 1'b0, 1'b0);
    Rst = 1'b1; step(1); Rst = 1'b0;
    drive(1'b1, rnd_ent(), 1'b0, 1'b0); step(1);
    drive(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      step(i % 4096 == 0);
    end
    step(1);
`ifdef PIPE_STALL_CNT_EN
    chk("stall_sat", 72'(bus.stall_cnt), 72'(16'hFFFF));
`else
    chk("stall_off", 72'(bus.stall_cnt), 72'(16'h0000));
`endif
    drive(1'b0, '0, 1'b0, 1'b1); step(1);
    drive(1'b0, '0, 1'b0, 1'b0); step(1);
    chk("stall_after_flush", 72'(bus.stall_cnt), 72'(exp_stall));
    chk("stall_flush_valid", 72'(bus.out_valid), 72'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
